// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: branch/writeback encodings, ALU flag indices and the MEM-stage slot layout
package ex_mem_reg_pkg;
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_type_e;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;
  localparam int T_EQ  = 0;
  localparam int T_LT  = 1;
  localparam int T_LTU = 2;
  typedef struct packed {
    logic        valid;
    logic [31:0] alu_y;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  wb_sel;
    logic [31:0] pc_plus4;
  } mem_slot_t;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: decodes branch funct3 against ALU flags (br_type, alu_t in; cond out), 010/011 never taken
module branch_cond
  import ex_mem_reg_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic [2:0] alu_t,
  output logic       cond
);
  always_comb
    cond = (br_type == BEQ)  ?  alu_t[T_EQ]  :
           (br_type == BNE)  ? !alu_t[T_EQ]  :
           (br_type == BLT)  ?  alu_t[T_LT]  :
           (br_type == BGE)  ? !alu_t[T_LT]  :
           (br_type == BLTU) ?  alu_t[T_LTU] :
           (br_type == BGEU) ? !alu_t[T_LTU] : 1'b0;
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with branch resolution, one-cycle redirect pulse and branch/taken counters; all outputs registered
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] alu_y,
  input  logic [2:0]  alu_t,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd,
  input  logic [2:0]  br_type,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        reg_we,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [1:0]  wb_sel,
  output logic        out_valid,
  output logic [31:0] out_alu_y,
  output logic [31:0] out_rs2_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_we,
  output logic        out_mem_we,
  output logic        out_mem_re,
  output logic [1:0]  out_wb_sel,
  output logic [31:0] out_pc_plus4,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] taken_cnt
);
  mem_slot_t   slot_d, slot_q;
  logic        cond, taken_d, redirect_q;
  logic [31:0] target_d, redirect_pc_q;
  logic [31:0] br_cnt_d, br_cnt_q, taken_cnt_d, taken_cnt_q;
  branch_cond u_branch_cond (
    .br_type (br_type),
    .alu_t   (alu_t),
    .cond    (cond)
  );
  always_comb begin
    taken_d     = in_valid & ((is_branch & cond) | is_jal | is_jalr);
    target_d    = is_jalr ? (alu_y & 32'hFFFF_FFFE) : pc + imm;
    br_cnt_d    = br_cnt_q + {31'd0, in_valid & is_branch};
    taken_cnt_d = taken_cnt_q + {31'd0, taken_d};
    slot_d      = '{valid:    in_valid,
                    alu_y:    alu_y,
                    rs2_data: rs2_data,
                    rd:       rd,
                    reg_we:   in_valid & reg_we,
                    mem_we:   in_valid & mem_we,
                    mem_re:   in_valid & mem_re,
                    wb_sel:   wb_sel,
                    pc_plus4: pc + 32'd4};
  end
  // redirect is cleared on every non-load edge so a held entry never re-issues it
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else if (flush) begin
      slot_q.valid  <= 1'b0;
      slot_q.reg_we <= 1'b0;
      slot_q.mem_we <= 1'b0;
      slot_q.mem_re <= 1'b0;
      redirect_q    <= 1'b0;
    end else if (stall) begin
      redirect_q    <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      redirect_q    <= taken_d;
      redirect_pc_q <= target_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end
  assign out_valid    = slot_q.valid;
  assign out_alu_y    = slot_q.alu_y;
  assign out_rs2_data = slot_q.rs2_data;
  assign out_rd       = slot_q.rd;
  assign out_reg_we   = slot_q.reg_we;
  assign out_mem_we   = slot_q.mem_we;
  assign out_mem_re   = slot_q.mem_re;
  assign out_wb_sel   = slot_q.wb_sel;
  assign out_pc_plus4 = slot_q.pc_plus4;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign br_cnt       = br_cnt_q;
  assign taken_cnt    = taken_cnt_q;
endmodule
